// File: rtl/banked_memory_pkg.sv
// Shared types and sizing helpers for banked_memory.
package banked_memory_pkg;

    typedef enum logic {
        StInit,
        StReady
    } state_e;

    // Number of banks selected by a bank-select field of the given width.
    function automatic int unsigned bank_count(input int unsigned bank_sel_w);
        return 32'd1 << bank_sel_w;
    endfunction

    // Width of the full request address (bank select + word offset).
    function automatic int unsigned total_addr_w(input int unsigned bank_addr_w,
                                                 input int unsigned bank_sel_w);
        return bank_addr_w + bank_sel_w;
    endfunction

endpackage

// File: rtl/banked_memory_if.sv
// Request/response bus of banked_memory.
interface banked_memory_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/banked_memory_memory_bank.sv
// One RAM bank: synchronous write, registered read.
// The read register is reset so the response data clears with the block.
module memory_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array write; contents are not reset, the init sweep clears them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; holds its value until the next read of this bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/banked_memory.sv
// Multi-bank single-port RAM with valid/ready requests and an init sweep after reset.
// Optional embedded read-after-write checker: define BANKED_MEMORY_FORMAL_EN.
module banked_memory
    import banked_memory_pkg::*;
#(
    parameter int unsigned          DATA_W      = 8,
    parameter int unsigned          BANK_ADDR_W = 14,
    parameter int unsigned          BANK_SEL_W  = 2,
    parameter logic [DATA_W-1:0]    INIT_VALUE  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    banked_memory_if.slave  bus,
    output logic            init_done
);
    localparam int unsigned NUM_BANKS = bank_count(BANK_SEL_W);
    localparam int unsigned ADDR_W    = total_addr_w(BANK_ADDR_W, BANK_SEL_W);
    localparam logic [BANK_ADDR_W-1:0] INIT_LAST = '1;

    state_e                 state;
    logic [BANK_ADDR_W-1:0] init_addr;
    logic                   ready;
    logic                   rsp_valid;
    logic [BANK_SEL_W-1:0]  bank_sel_q;

    logic [BANK_SEL_W-1:0]  req_sel;
    logic [BANK_ADDR_W-1:0] req_off;
    logic                   fire;
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   in_init;
    logic [DATA_W-1:0]      bank_rdata [NUM_BANKS];

    assign req_sel = bus.req_addr[ADDR_W-1 -: BANK_SEL_W];
    assign req_off = bus.req_addr[BANK_ADDR_W-1:0];
    assign fire    = bus.req_valid && ready;
    assign wr_fire = fire && bus.req_wen;
    assign rd_fire = fire && !bus.req_wen;
    assign in_init = (state == StInit);

    // Init sweep FSM with registered ready/done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StInit;
            init_addr <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                StInit: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == INIT_LAST) begin
                        state <= StReady;
                        ready <= 1'b1;
                    end
                end
                StReady: begin
                    ready <= 1'b1;
                end
                default: state <= StInit;
            endcase
        end
    end

    // Response valid pulse and the bank select that steers the read-data mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            bank_sel_q <= '0;
        end else begin
            rsp_valid <= rd_fire;
            if (rd_fire) begin
                bank_sel_q <= req_sel;
            end
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic hit;
        assign hit = (req_sel == BANK_SEL_W'(i));

        memory_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (BANK_ADDR_W)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (in_init || (wr_fire && hit)),
            .re    (rd_fire && hit),
            .addr  (in_init ? init_addr : req_off),
            .wdata (in_init ? INIT_VALUE : bus.req_wdata),
            .rdata (bank_rdata[i])
        );
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = bank_rdata[bank_sel_q];
    assign init_done     = ready;

`ifdef BANKED_MEMORY_FORMAL_EN
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_shadow;
    logic              f_shadow_valid;
    logic              f_rd_hit;

    // Unreset self-holding register: free initial value, constant thereafter.
    always_ff @(posedge clk) begin
        f_addr <= f_addr;
    end

    // Shadow the last write to the test address; note reads that target it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_shadow       <= '0;
            f_shadow_valid <= 1'b0;
            f_rd_hit       <= 1'b0;
        end else begin
            f_rd_hit <= rd_fire && (bus.req_addr == f_addr);
            if (wr_fire && (bus.req_addr == f_addr)) begin
                f_shadow       <= bus.req_wdata;
                f_shadow_valid <= 1'b1;
            end
        end
    end

    // Read data for the test address matches the last write, or the init value.
    always_comb begin
        if (rst_n && bus.rsp_valid && f_rd_hit) begin
            if (f_shadow_valid) begin
                assert (bus.rsp_rdata == f_shadow);
            end else begin
                assert (bus.rsp_rdata == INIT_VALUE);
            end
        end
        cover (state == StReady);
    end
`else
    // Plain RAM build: no checker logic.
`endif

endmodule

// File: tb/tb_banked_memory.sv
// Scoreboard bench for banked_memory: random and directed requests against an array model.
module tb_banked_memory;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned BANK_ADDR_W = 4;
    localparam int unsigned BANK_SEL_W  = 2;
    localparam int unsigned ADDR_W      = BANK_ADDR_W + BANK_SEL_W;
    localparam int unsigned WORDS       = 1 << ADDR_W;
    localparam int unsigned INIT_CYC    = 1 << BANK_ADDR_W;
    localparam logic [DATA_W-1:0] INIT_VALUE = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;

    banked_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    banked_memory #(
        .DATA_W      (DATA_W),
        .BANK_ADDR_W (BANK_ADDR_W),
        .BANK_SEL_W  (BANK_SEL_W),
        .INIT_VALUE  (INIT_VALUE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ref_mem [WORDS];
    logic [DATA_W-1:0] exp_data [$];
    int                exp_cyc [$];
    logic [DATA_W-1:0] last_exp = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) ref_mem[i] = INIT_VALUE;
        exp_data.delete();
        exp_cyc.delete();
        last_exp = '0;
    endtask

    // One request, accepted at the next edge; the model and scoreboard follow.
    task automatic issue(input logic wen, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        if (wen) begin
            ref_mem[addr] = wdata;
        end else begin
            exp_data.push_back(ref_mem[addr]);
            exp_cyc.push_back(cyc);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ready/done must stay low for the whole sweep and rise right after it.
    task automatic wait_init(input bit poke);
        for (int k = 1; k <= INIT_CYC; k++) begin
            if (poke && k == 1) begin
                bus.req_valid = 1'b1;
                bus.req_wen   = 1'b1;
                bus.req_addr  = 6'h10;
                bus.req_wdata = 8'hFF;
            end
            if (k == INIT_CYC - 4) bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("init_ready", {31'd0, bus.req_ready}, {31'd0, k == INIT_CYC});
            chk("init_done", {31'd0, init_done}, {31'd0, k == INIT_CYC});
        end
    endtask

    // Monitor: every response pops the scoreboard; between responses the data must hold.
    always @(negedge clk) begin
        logic [DATA_W-1:0] d;
        int c;
        if (rst_n) begin
            if (bus.rsp_valid) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%0h, expected no response",
                             bus.rsp_rdata);
                end else begin
                    d = exp_data.pop_front();
                    c = exp_cyc.pop_front();
                    chk("rsp_cycle", cyc, c);
                    chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, d});
                    last_exp = d;
                end
            end else begin
                chk("rdata_hold", {24'd0, bus.rsp_rdata}, {24'd0, last_exp});
            end
        end
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        model_reset();

        #3;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init(1'b1);

        // Reads after init, including the address poked during the sweep.
        issue(1'b0, 6'h3F, 8'h00);
        issue(1'b0, 6'h10, 8'h00);
        idle(2);

        // Bank isolation.
        issue(1'b1, 6'h25, 8'hA5);
        issue(1'b0, 6'h25, 8'h00);
        issue(1'b0, 6'h05, 8'h00);
        issue(1'b0, 6'h15, 8'h00);
        issue(1'b0, 6'h35, 8'h00);
        idle(1);

        // Read immediately after write.
        issue(1'b1, 6'h0F, 8'h3C);
        issue(1'b0, 6'h0F, 8'h00);
        idle(2);

        // Full fill then back-to-back readback.
        for (int a = 0; a < WORDS; a++) begin
            issue(1'b1, ADDR_W'(a), DATA_W'(a) ^ 8'h5A);
        end
        for (int a = 0; a < WORDS; a++) begin
            issue(1'b0, ADDR_W'(a), 8'h00);
        end
        idle(2);

        // Random mix with idle gaps.
        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, WORDS - 1)),
                  DATA_W'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        // Reset in the middle of a read stream.
        for (int a = 0; a < 5; a++) issue(1'b0, ADDR_W'(a * 7), 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("midrst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(1'b0);

        issue(1'b0, 6'h2A, 8'h00);
        for (int n = 0; n < 20; n++) begin
            issue(1'b0, ADDR_W'($urandom_range(0, WORDS - 1)), 8'h00);
        end
        idle(4);

        chk("outstanding", exp_data.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case the DUT wedges.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion before 200000");
        $fatal(1);
    end
endmodule
